// File: rtl/shift_compare_unit.sv
// rtl/shift_compare_unit.sv - iterative unsigned compare and one-bit-per-clock shift engine
//
// Captures a_in/b_in on start, compares them unsigned, then shifts the
// selected operand by shamt positions, one position per clock.
//   A < B : C = A shifted left
//   A > B : C = B shifted right (sign-fill when arith)
//   A == B: C = A, no shift cycles
// Optional build macro SHIFT_ROTATE_EN adds the rot input; with rot=1 both
// directions rotate instead of shifting and arith is ignored.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               request, accepted only while idle
//   a_in, b_in          operands, captured on an accepted start
//   shamt, arith, (rot) shift count and mode, captured with start
//   A, B                captured operands
//   C                   result register
//   busy                high while an operation is in flight
//   done                one-cycle pulse when C is final
//   lt, gt, eq          registered unsigned compare flags of A versus B
module shift_compare_unit #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
`ifdef SHIFT_ROTATE_EN
  input  logic               rot,
`endif
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic               lt,
  output logic               gt,
  output logic               eq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CMP   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_left;
  logic               arith_q;
  logic               rot_q;
  logic [WIDTH-1:0]   c_left;
  logic [WIDTH-1:0]   c_right;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CMP;
      // Equal operands force an effective shift count of zero.
      S_CMP:   state_nx = ((A == B) || (cnt == '0)) ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == SHAMT_W'(1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // One-position shift of the result register in either direction.
  always_comb begin
    c_left  = rot_q ? {C[WIDTH-2:0], C[WIDTH-1]} : {C[WIDTH-2:0], 1'b0};
    c_right = rot_q ? {C[0], C[WIDTH-1:1]}
                    : {(arith_q & C[WIDTH-1]), C[WIDTH-1:1]};
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      A        <= '0;
      B        <= '0;
      C        <= '0;
      lt       <= 1'b0;
      gt       <= 1'b0;
      eq       <= 1'b0;
      cnt      <= '0;
      dir_left <= 1'b0;
      arith_q  <= 1'b0;
`ifdef SHIFT_ROTATE_EN
      rot_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            A       <= a_in;
            B       <= b_in;
            cnt     <= shamt;
            arith_q <= arith;
`ifdef SHIFT_ROTATE_EN
            rot_q   <= rot;
`endif
          end
        end
        S_CMP: begin
          lt       <= (A < B);
          gt       <= (A > B);
          eq       <= (A == B);
          C        <= (A > B) ? B : A;
          dir_left <= (A < B);
          if (A == B) cnt <= '0;
        end
        S_SHIFT: begin
          C   <= dir_left ? c_left : c_right;
          cnt <= cnt - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifndef SHIFT_ROTATE_EN
  assign rot_q = 1'b0;
`endif

endmodule

// File: tb/tb_shift_compare_unit.sv
// tb/tb_shift_compare_unit.sv - self-checking bench for shift_compare_unit
module tb_shift_compare_unit;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [SW-1:0] shamt;
  logic          arith;
  logic          rot;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic [W-1:0]  C;
  logic          busy;
  logic          done;
  logic          lt;
  logic          gt;
  logic          eq;

  int n_pass  = 0;
  int n_total = 0;

  shift_compare_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .shamt (shamt),
    .arith (arith),
`ifdef SHIFT_ROTATE_EN
    .rot   (rot),
`endif
    .A     (A),
    .B     (B),
    .C     (C),
    .busy  (busy),
    .done  (done),
    .lt    (lt),
    .gt    (gt),
    .eq    (eq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Single-step reference: the final result written as one arithmetic expression.
  function automatic logic [W-1:0] ref_c(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input int k, input logic ar, input logic rt);
    logic [2*W-1:0] t;
    if (a < b) begin
      if (rt) begin
        t = {a, a} << k;
        return t[2*W-1:W];
      end
      t = {{W{1'b0}}, a} << k;
      return t[W-1:0];
    end else if (a > b) begin
      if (rt) begin
        t = {b, b} >> k;
        return t[W-1:0];
      end
      if (ar) return W'($signed(b) >>> k);
      return b >> k;
    end
    return a;
  endfunction

  // Run one operation and check latency, result, flags and the done pulse.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] k, input logic ar, input logic rt,
                        input bit hold);
    int cyc;
    int keff;
    logic [W-1:0] ec;
    ec   = ref_c(a, b, int'(k), ar, rt);
    keff = (a == b) ? 0 : int'(k);
    @(negedge clk);
    a_in = a; b_in = b; shamt = k; arith = ar; rot = rt; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    shamt = SW'($urandom);
    @(negedge clk);
    chk({tag, "_busy_cmp"}, 32'(busy), 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(keff + 2));
    chk({tag, "_C"},  32'(C),  32'(ec));
    chk({tag, "_A"},  32'(A),  32'(a));
    chk({tag, "_B"},  32'(B),  32'(b));
    chk({tag, "_flags"}, {29'd0, lt, gt, eq},
        {29'd0, (a < b), (a > b), (a == b)});
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ha, hb, hc;
    int           seen;
    logic [W-1:0] ra, rb;
    logic [SW-1:0] rk;
    logic          rr;

    reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; shamt = '0; arith = 1'b0; rot = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {A, B, C, 8'd0}, 32'd0);
    chk("reset_ctrl", {27'd0, busy, done, lt, gt, eq}, 32'd0);
    reset = 1'b0;

    // Directed cases from the plan
    run_op("tp1", 8'h05, 8'h10, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("tp1_C_const", 32'(C), 32'h14);
    run_op("tp2a", 8'h90, 8'h84, 3'd3, 1'b1, 1'b0, 1'b0);
    chk("tp2a_C_const", 32'(C), 32'hF0);
    run_op("tp2l", 8'h90, 8'h84, 3'd3, 1'b0, 1'b0, 1'b0);
    chk("tp2l_C_const", 32'(C), 32'h10);
    run_op("tp3eq", 8'h3C, 8'h3C, 3'd5, 1'b0, 1'b0, 1'b0);
    chk("tp3eq_C_const", 32'(C), 32'h3C);
    run_op("tp3k0", 8'h01, 8'h02, 3'd0, 1'b0, 1'b0, 1'b0);
    chk("tp3k0_C_const", 32'(C), 32'h01);

    // start held through a k=7 operation
    run_op("tp4hold", 8'h01, 8'hFE, 3'd7, 1'b0, 1'b0, 1'b1);
    chk("tp4hold_C_const", 32'(C), 32'h80);
    ha = A; hb = B; hc = C;
    repeat (4) begin
      @(negedge clk);
      a_in = W'($urandom); b_in = W'($urandom); shamt = SW'($urandom);
    end
    @(negedge clk);
    chk("tp4_hold_regs", {8'd0, A, B, C}, {8'd0, ha, hb, hc});
    chk("tp4_hold_ctrl", {30'd0, busy, done}, 32'd0);

    // Reset during SHIFT
    @(negedge clk);
    a_in = 8'h03; b_in = 8'h40; shamt = 3'd6; arith = 1'b0; rot = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("tp5_in_shift", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("tp5_reset_regs", {8'd0, A, B, C}, 32'd0);
    chk("tp5_reset_ctrl", {27'd0, busy, done, lt, gt, eq}, 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("tp5_no_done", 32'(seen), 32'd0);
    run_op("tp5_after", 8'h03, 8'h40, 3'd6, 1'b0, 1'b0, 1'b0);
    chk("tp5_after_C_const", 32'(C), 32'hC0);

    // Rotate option
    run_op("tp6_norot", 8'h81, 8'hFF, 3'd1, 1'b0, 1'b0, 1'b0);
    chk("tp6_norot_C_const", 32'(C), 32'h02);
`ifdef SHIFT_ROTATE_EN
    run_op("tp6_rot", 8'h81, 8'hFF, 3'd1, 1'b0, 1'b1, 1'b0);
    chk("tp6_rot_C_const", 32'(C), 32'h03);
`endif

    // Randomized operations against the reference
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = (i % 6 == 0) ? ra : W'($urandom);
      rk = SW'($urandom);
      rr = 1'b0;
`ifdef SHIFT_ROTATE_EN
      rr = 1'($urandom);
`endif
      run_op($sformatf("rnd%0d", i), ra, rb, rk, 1'($urandom), rr, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shift_compare_unit.md
Name: shift_compare_unit

Overview:
- Parametrised, multi-cycle successor to the 4-bit compare-and-shift block.
- Captures two WIDTH-bit operands on start and compares them unsigned.
- Shifts the selected operand by a programmable amount, one bit per clock.
- Presents the result with busy/done handshake and registered compare flags. Sits in the datapath as a small iterative shift engine.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)
SHAMT_W, 3, shift-amount width; must equal $clog2(WIDTH), so shamt < WIDTH always

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
shamt  input  SHAMT_W  shift count k, sampled with start
arith  input  1  1 = right shifts sign-fill from MSB, 0 = zero-fill; sampled with start
A  output  WIDTH  captured operand A (registered)
B  output  WIDTH  captured operand B (registered)
C  output  WIDTH  result register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, result valid
lt, gt, eq  output  1 each  registered compare flags, one-hot after first compare

Behaviour:
- Reset (synchronous, active-high, overrides all): at the next edge A, B, C, lt, gt, eq, done = 0; busy = 0; state = IDLE; shift counter = 0. A reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CMP, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: A<=a_in, B<=b_in; counter<=shamt; latch arith (and rot); go to CMP.
  - start=0: stay in IDLE; all outputs hold.
- CMP (one cycle), at edge E0+1:
  - Compare captured A, B unsigned; set exactly one of lt/gt/eq.
  - A<B: C<=A, direction = left.
  - A>B: C<=B, direction = right.
  - A==B: C<=A, no shift; effective k = 0.
  - Next state: DONE if effective k==0, else SHIFT.
- SHIFT (one bit per edge):
  - Left: C<=C<<1 with zero fill; MSB is discarded and no overflow flag is raised.
  - Right: C<=C>>1; fill bit = C[WIDTH-1] if arith else 0.
  - Decrement counter each edge; go to DONE on the edge where counter goes 1->0.
- DONE: done=1 for exactly one cycle; busy stays 1; next edge returns to IDLE.
- Latency: done is high in the cycle after edge E0+1+k. Minimum start-to-start spacing is k+3 cycles.
- start while busy (CMP/SHIFT/DONE) is ignored; it is not queued.
- Hold rules: C, A, B and the flags hold their values until the next accepted start; done=0 outside DONE.
- Final C equals the single-cycle result (A<<k, B>>k or B>>>k, or A). Bits shifted out are lost.

Optional Feature:
- Macro SHIFT_ROTATE_EN.
- Defined: adds input port rot (1 bit), sampled with start. When rot=1, left shifts rotate (MSB re-enters at LSB) and right shifts rotate (LSB re-enters at MSB); arith is ignored. When rot=0, behaviour is identical to the build without the macro.
- Undefined: the rot port is absent and only plain shifts exist.

Test Plan:
1. a_in=0x05, b_in=0x10, shamt=2, arith=0 -> lt=1, C=0x14; done high after edge E0+3; busy low the following cycle.
2. a_in=0x90, b_in=0x84, shamt=3 -> gt=1. With arith=1: C=0xF0. With arith=0: C=0x10. In both cases done follows edge E0+4.
3. a_in=b_in=0x3C, shamt=5 -> eq=1, C=0x3C, done follows edge E0+1 (no shift cycles). Also a_in=0x01, b_in=0x02, shamt=0 -> lt=1, C=0x01, done follows edge E0+1.
4. Busy handling: start held high throughout a k=7 operation -> exactly one done pulse. A new capture occurs only after returning to IDLE. A, B and C stay stable between operations.
5. Reset mid-operation: assert reset during SHIFT with k=6 -> next edge all outputs 0, state IDLE, no done pulse. A start after reset deasserts runs normally.
6. SHIFT_ROTATE_EN defined, a_in=0x81, b_in=0xFF, shamt=1, rot=1 -> C=0x03. Same stimulus with rot=0, or with the macro undefined -> C=0x02.
